// File: rtl/button_counter.sv
// Two-button (up/down) synchroniser, debouncer and modulo-2^WIDTH up/down counter.
// Optional auto-repeat while held is enabled by defining BUTTON_COUNTER_AUTOREPEAT_EN.
module button_counter #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             ipClk,
    input  logic             ipnReset,
    input  logic [1:0]       ipnButton,
    output logic [1:0]       opPressed,
    output logic [WIDTH-1:0] opCount
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            stable_q, stable_d;
    logic [1:0]            pressed_q, pressed_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [1:0]            sync_s;
    logic [1:0]            press_s;

`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]            rpt_phase_q, rpt_phase_d;
    logic [1:0]            rpt_fire_s;
`endif

    // A configuration that breaks the debounce/repeat arithmetic shows up as this named scope.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_invalid_cfg
    end

    // Next-state logic: synchronise, debounce, pulse generation and count update.
    always_comb begin
        sync1_d  = ipnButton;
        sync2_d  = sync1_q;
        sync_s   = ~sync2_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;

        for (int i = 0; i < 2; i++) begin
            if (sync_s[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync_s[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end

        // Only the released-to-pressed transition is an event.
        press_s = stable_d & ~stable_q;

`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        rpt_fire_s  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (stable_q[i] && stable_d[i]) begin
                if (rpt_cnt_q[i] == (rpt_phase_q[i] ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                    rpt_fire_s[i]  = 1'b1;
                    rpt_cnt_d[i]   = '0;
                    rpt_phase_d[i] = 1'b1;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                end
            end else begin
                rpt_cnt_d[i]   = '0;
                rpt_phase_d[i] = 1'b0;
            end
        end
        pressed_d = press_s | rpt_fire_s;
`else
        pressed_d = press_s;
`endif

        case (pressed_d)
            2'b01:   count_d = count_q + WIDTH'(1);
            2'b10:   count_d = count_q - WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge ipClk) begin
        if (!ipnReset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            stable_q  <= 2'b00;
            db_cnt_q  <= '0;
            pressed_q <= 2'b00;
            count_q   <= '0;
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 2'b00;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
            count_q   <= count_d;
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
`endif
        end
    end

    assign opPressed = pressed_q;
    assign opCount   = count_q;

endmodule

// File: tb/tb_button_counter.sv
// Randomised and directed bench for button_counter, checked against a cycle-level behavioural model.
module tb_button_counter;

    localparam int W  = 8;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         ipClk     = 1'b0;
    logic         ipnReset  = 1'b0;
    logic [1:0]   ipnButton = 2'b11;
    logic [1:0]   opPressed;
    logic [W-1:0] opCount;

    button_counter #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .ipClk(ipClk),
        .ipnReset(ipnReset),
        .ipnButton(ipnButton),
        .opPressed(opPressed),
        .opCount(opCount)
    );

    always #5 ipClk = ~ipClk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: raw samples delayed two edges, a run length of disagreeing
    // samples per button, elapsed cycles since press, and an integer count.
    bit [1:0] samp_q[$] = '{2'b11, 2'b11};
    bit [1:0] stable_m  = 2'b00;
    bit [1:0] pulse_m   = 2'b00;
    int       run_m[2]  = '{0, 0};
    int       held_m[2] = '{0, 0};
    int       count_m   = 0;

    int up_pulses[$];
    int dn_pulses[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit [1:0] btn);
        bit [1:0] lvl;
        bit [1:0] pulse;
        bit       just_pressed;
        pulse = 2'b00;
        if (!rst_n) begin
            samp_q    = '{2'b11, 2'b11};
            stable_m  = 2'b00;
            pulse_m   = 2'b00;
            run_m     = '{0, 0};
            held_m    = '{0, 0};
            count_m   = 0;
            return;
        end
        lvl = ~samp_q[0];
        for (int i = 0; i < 2; i++) begin
            just_pressed = 1'b0;
            if (lvl[i] == stable_m[i]) begin
                run_m[i] = 0;
            end else begin
                run_m[i]++;
                if (run_m[i] == DB) begin
                    stable_m[i] = lvl[i];
                    run_m[i]    = 0;
                    if (stable_m[i]) begin
                        pulse[i]     = 1'b1;
                        just_pressed = 1'b1;
                        held_m[i]    = 0;
                    end
                end
            end
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
            if (stable_m[i] && !just_pressed) begin
                held_m[i]++;
                if (held_m[i] == RD || (held_m[i] > RD && (held_m[i] - RD) % RP == 0))
                    pulse[i] = 1'b1;
            end
`endif
        end
        if (pulse == 2'b01) count_m = (count_m + 1) % (2 ** W);
        if (pulse == 2'b10) count_m = (count_m + (2 ** W) - 1) % (2 ** W);
        pulse_m = pulse;
        void'(samp_q.pop_front());
        samp_q.push_back(btn);
    endtask

    task automatic tick(input bit rst_n, input bit [1:0] btn);
        ipnReset  = rst_n;
        ipnButton = btn;
        @(posedge ipClk);
        cyc++;
        model_step(rst_n, btn);
        #1;
        check_eq("pressed", 32'(opPressed), 32'(pulse_m));
        check_eq("count", 32'(opCount), 32'(count_m));
        if (opPressed[0] === 1'b1) up_pulses.push_back(cyc);
        if (opPressed[1] === 1'b1) dn_pulses.push_back(cyc);
    endtask

    task automatic hold(input bit [1:0] btn, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, btn);
    endtask

    task automatic press_release(input bit [1:0] btn);
        hold(btn, 6);
        hold(2'b11, 6);
    endtask

    initial begin
        int start;
        int rst_cyc;

        // Reset and idle
        hold(2'b11, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'b11);
        check_eq("reset_count", 32'(opCount), 32'd0);
        check_eq("reset_pressed", 32'(opPressed), 32'd0);
        up_pulses.delete();
        dn_pulses.delete();
        hold(2'b11, 50);
        check_eq("idle_pulses", 32'(up_pulses.size() + dn_pulses.size()), 32'd0);
        check_eq("idle_count", 32'(opCount), 32'd0);

        // Single up press: latency and release without pulse
        start = cyc + 1;
        hold(2'b10, 8);
        check_eq("up_pulse_count", 32'(up_pulses.size()), 32'd1);
        if (up_pulses.size() == 1)
            check_eq("up_latency", 32'(up_pulses[0] - start), 32'd5);
        check_eq("count_after_up", 32'(opCount), 32'd1);
        hold(2'b11, 8);
        check_eq("up_release_pulses", 32'(up_pulses.size()), 32'd1);

        // Bounce that never qualifies
        hold(2'b10, 3);
        hold(2'b11, 1);
        hold(2'b10, 3);
        hold(2'b11, 8);
        check_eq("bounce_pulses", 32'(up_pulses.size()), 32'd1);
        check_eq("bounce_count", 32'(opCount), 32'd1);

        // Wrap-around upward and downward
        press_release(2'b01);
        check_eq("back_to_zero", 32'(opCount), 32'd0);
        for (int i = 0; i < 256; i++) press_release(2'b10);
        check_eq("wrap_up", 32'(opCount), 32'd0);
        press_release(2'b01);
        check_eq("wrap_down", 32'(opCount), 32'd255);
        press_release(2'b10);

        // Simultaneous presses cancel
        up_pulses.delete();
        dn_pulses.delete();
        hold(2'b00, 8);
        check_eq("both_up_pulses", 32'(up_pulses.size()), 32'd1);
        check_eq("both_dn_pulses", 32'(dn_pulses.size()), 32'd1);
        if (up_pulses.size() == 1 && dn_pulses.size() == 1)
            check_eq("both_same_edge", 32'(up_pulses[0]), 32'(dn_pulses[0]));
        check_eq("both_count", 32'(opCount), 32'd0);
        hold(2'b11, 8);

        // Reset in the middle of qualification with down held
        dn_pulses.delete();
        hold(2'b01, 4);
        tick(1'b0, 2'b01);
        rst_cyc = cyc;
        check_eq("mid_reset_pressed", 32'(opPressed), 32'd0);
        hold(2'b01, 10);
        check_eq("mid_reset_pulses", 32'(dn_pulses.size()), 32'd1);
        check_eq("mid_reset_count", 32'(opCount), 32'd255);
        if (dn_pulses.size() == 1)
            check_eq("mid_reset_after", 32'(dn_pulses[0] > rst_cyc), 32'd1);
        hold(2'b11, 8);

`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
        // Auto-repeat cadence while up is held
        tick(1'b0, 2'b11);
        up_pulses.delete();
        hold(2'b10, 25);
        check_eq("rpt_pulse_count", 32'(up_pulses.size()), 32'd5);
        if (up_pulses.size() >= 4) begin
            check_eq("rpt_first", 32'(up_pulses[1] - up_pulses[0]), 32'd10);
            check_eq("rpt_second", 32'(up_pulses[2] - up_pulses[0]), 32'd13);
            check_eq("rpt_third", 32'(up_pulses[3] - up_pulses[0]), 32'd16);
        end
        check_eq("rpt_count", 32'(opCount), 32'd5);
        hold(2'b11, 8);
`endif

        // Random button activity with occasional resets
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(99) == 0) tick(1'b0, 2'(($urandom)));
            else hold(2'($urandom), int'($urandom_range(8, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
